// File: rtl/zsdram_rr_arbiter.sv
// rtl/zsdram_rr_arbiter.sv - N-port round-robin burst arbiter in front of the SDRAM base controller
// Optional build macro: ZARB_PORT0_PRIORITY_EN (port 0 always wins arbitration when requesting).
module zsdram_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int BURST     = 4,
  parameter int PTR_W     = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic [NUM_PORTS-1:0]              iReq,
  input  logic [NUM_PORTS-1:0]              iWe,
  input  logic [NUM_PORTS*ADDR_W-1:0]       iAddr,
  input  logic [NUM_PORTS*BURST*DATA_W-1:0] iWrData,
  output logic [NUM_PORTS-1:0]              oDone,
  output logic [BURST*DATA_W-1:0]           oRdData,
  output logic [PTR_W-1:0]                  oGrant,
  output logic                              oBusy,
  output logic [1:0]                        oSdReq,
  output logic [ADDR_W-1:0]                 oSdAddr,
  output logic [BURST*DATA_W-1:0]           oSdWrData,
  input  logic [BURST*DATA_W-1:0]           iSdRdData,
  input  logic [1:0]                        iSdDone
);

  localparam int BW = BURST * DATA_W;

  typedef enum logic [1:0] {IDLE, BUSY, ACK, GAP} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q;
  logic [PTR_W-1:0]     ptr_next;
  logic                 we_q;
  logic [PTR_W-1:0]     pick;
  logic [PTR_W-1:0]     cand;
  logic [PTR_W:0]       sum;
  logic                 found;
  logic                 any_req;
  logic                 done_hit;
  logic                 grant_now;
  logic                 ack_now;
  logic                 ptr_adv;
  logic [1:0]           sd_req_d;
  logic [NUM_PORTS-1:0] done_d;

  assign any_req   = |iReq;
  assign done_hit  = we_q ? iSdDone[1] : iSdDone[0];
  assign grant_now = en && (state_q == IDLE) && any_req;
  assign ack_now   = en && (state_q == ACK);
  assign ptr_next  = (oGrant == PTR_W'(NUM_PORTS - 1)) ? '0 : oGrant + 1'b1;

`ifdef ZARB_PORT0_PRIORITY_EN
  // Port 0 grants leave the rotation untouched so ports 1..N-1 keep their fairness.
  assign ptr_adv = (oGrant != '0);
`else
  assign ptr_adv = 1'b1;
`endif

  // First requester at or above ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    pick  = '0;
    cand  = '0;
    sum   = '0;
    found = 1'b0;
`ifdef ZARB_PORT0_PRIORITY_EN
    if (iReq[0]) begin
      found = 1'b1;
    end
`endif
    for (int i = 0; i < NUM_PORTS; i++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(NUM_PORTS)) begin
        sum = sum - (PTR_W+1)'(NUM_PORTS);
      end
      cand = sum[PTR_W-1:0];
`ifdef ZARB_PORT0_PRIORITY_EN
      if (!found && (cand != '0) && iReq[cand]) begin
`else
      if (!found && iReq[cand]) begin
`endif
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        IDLE:    if (any_req)  state_d = BUSY;
        BUSY:    if (done_hit) state_d = ACK;
        ACK:     state_d = GAP;
        GAP:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // With en low both strobes drop; the latched command is replayed when en returns.
  always_comb begin
    sd_req_d = 2'b00;
    done_d   = '0;
    if (en) begin
      case (state_q)
        IDLE: if (any_req) sd_req_d = iWe[pick] ? 2'b10 : 2'b01;
        BUSY: begin
          if (done_hit) done_d = NUM_PORTS'(1) << oGrant;
          else          sd_req_d = we_q ? 2'b10 : 2'b01;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      we_q      <= 1'b0;
      oGrant    <= '0;
      oBusy     <= 1'b0;
      oSdReq    <= 2'b00;
      oDone     <= '0;
      oSdAddr   <= '0;
      oSdWrData <= '0;
      oRdData   <= '0;
    end else begin
      oSdReq <= sd_req_d;
      oDone  <= done_d;
      oBusy  <= (state_d != IDLE);
      if (grant_now) begin
        oGrant    <= pick;
        we_q      <= iWe[pick];
        oSdAddr   <= iAddr[pick*ADDR_W +: ADDR_W];
        oSdWrData <= iWrData[pick*BW +: BW];
      end
      if (en && (state_q == BUSY) && done_hit && !we_q) begin
        oRdData <= iSdRdData;
      end
      if (ack_now && ptr_adv) begin
        ptr_q <= ptr_next;
      end
    end
  end

endmodule

// File: doc/zsdram_rr_arbiter.md
Name: zsdram_rr_arbiter

Overview:
- Parametrised N-port SDRAM read/write arbiter; successor to the fixed 2-read/2-write arbiter.
- Each port carries its own direction bit, so any port can issue reads or writes.
- Grants one burst transaction at a time to the four-word SDRAM base controller, using round-robin priority.
- Sits between the TFT adapter / draw / shift engines and the SDRAM base controller.

Parameters:
- NUM_PORTS, 4, number of requester ports (2..8).
- ADDR_W, 24, SDRAM address width (bank+row+column).
- DATA_W, 16, SDRAM word width.
- BURST, 4, words per transaction (matches base controller four-word mode).
- PTR_W, 2, width of grant index; must equal ceil(log2(NUM_PORTS)).

Ports:
- clk  in  1  system clock (133 MHz SDRAM domain).
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  arbiter enable; low freezes the FSM.
- iReq  in  NUM_PORTS  per-port request; held high until that port's oDone.
- iWe  in  NUM_PORTS  per-port direction: 1=write, 0=read.
- iAddr  in  NUM_PORTS*ADDR_W  per-port address, port k at [k*ADDR_W +: ADDR_W].
- iWrData  in  NUM_PORTS*BURST*DATA_W  per-port write burst; word j of port k at [(k*BURST+j)*DATA_W +: DATA_W].
- oDone  out  NUM_PORTS  one-hot, one-cycle completion pulse.
- oRdData  out  BURST*DATA_W  shared read-burst output, valid from oDone onward.
- oGrant  out  PTR_W  index of the port currently or last served.
- oBusy  out  1  high from the grant cycle through the GAP state.
- oSdReq  out  2  to base controller: [1]=write, [0]=read.
- oSdAddr  out  ADDR_W  to base controller.
- oSdWrData  out  BURST*DATA_W  to base controller.
- iSdRdData  in  BURST*DATA_W  from base controller.
- iSdDone  in  2  from base controller: [1]=write done, [0]=read done.

Behaviour:
- Reset values:
  - state=IDLE; rr pointer=0.
  - oDone=0, oSdReq=0, oBusy=0, oGrant=0.
  - oRdData=0, oSdAddr=0, oSdWrData=0.
- IDLE:
  - If any iReq is set, pick the first requesting port searching upward from ptr, wrapping modulo NUM_PORTS.
  - Latch into output registers on the same edge: that port's address to oSdAddr, its data to oSdWrData, oGrant=k, oBusy=1, and oSdReq = iWe[k] ? 2'b10 : 2'b01.
  - Go to BUSY. oSdReq is high on the cycle after the request is first sampled.
- BUSY:
  - Hold oSdReq, oSdAddr and oSdWrData stable.
  - On the matching done bit (iSdDone[1] for a write, iSdDone[0] for a read): set oSdReq=0; on reads, capture iSdRdData into oRdData; go to ACK.
  - The non-matching done bit is ignored.
- ACK: oDone[oGrant]=1 for exactly one cycle; ptr = oGrant+1 (wraps to 0 after NUM_PORTS-1); go to GAP.
- GAP: one idle cycle, oDone=0, lets the requester drop iReq; oBusy=0 on exit; go to IDLE.
- A served port cannot be re-granted earlier than the IDLE after GAP.
- Minimum turnaround: request to done = 3 cycles + base controller latency.
- A port that drops iReq after being granted still completes its transaction and receives oDone.
- iReq/iWe/iAddr/iWrData changes after the grant are ignored until the next IDLE.
- oRdData holds until the next read completes; writes do not alter it.
- en low:
  - oSdReq and oDone are forced to 0 on the next edge.
  - state, ptr, latched address and data are held.
  - When en returns in BUSY, oSdReq is re-asserted with the same latched command.
- rst_n low at any time, including mid-burst, returns everything to the reset values immediately; an in-flight transaction is abandoned without oDone.

Optional Feature:
- Macro: ZARB_PORT0_PRIORITY_EN.
- Defined: in IDLE, port 0 wins whenever iReq[0]=1, regardless of ptr. This serves the TFT refresh read path. Other ports arbitrate round-robin among themselves, and ptr is updated only by grants to ports 1..N-1.
- Undefined: pure round-robin across all ports.

Test Plan:
- Single port read: iReq=4'b0001, iWe=0, addr 0x000100; base returns iSdDone=01 after 6 cycles with data 0x1111/2222/3333/4444 -> oSdReq=01 for those 6 cycles, oRdData matches, oDone=0001 for one cycle, oGrant=0.
- All four ports request simultaneously from reset, mixed directions -> grant order 0,1,2,3; each oSdReq matches its iWe; exactly one oDone pulse per port; no overlap.
- Port 2 holds iReq continuously and port 1 requests once -> grants alternate 2,1,2,2; port 2 is never granted twice back-to-back while port 1 is pending.
- en dropped for 5 cycles mid-BUSY on a write to 0xFFFFFF -> oSdReq=00 during the gap; after en returns, oSdReq=10 with the same address and data; single oDone.
- rst_n pulsed low mid-read -> all outputs return to 0 asynchronously; no oDone; next grant starts from port 0.
- ZARB_PORT0_PRIORITY_EN defined, ports 0 and 3 requesting continuously -> port 0 served every transaction; port 3 served only after iReq[0] drops.
